// File: rtl/current_off_ctrl.sv
// Over-current shutdown sequencer: debounces a synced fault flag, then holds the output
// disabled for a cooldown per trip and latches off after too many trips in a row.
module current_off_ctrl #(
  parameter int DEBOUNCE_CYC  = 4,
  parameter int COOLDOWN_CYC  = 1000,
  parameter int MAX_RETRY     = 3,
  parameter int RETRY_CLR_CYC = 100000,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       oc_fault_in,
  input  logic       clear,
  output logic       dis_out,
  output logic       trip_pulse,
  output logic       locked,
  output logic [7:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ARMED   = 3'd1,
    S_FILTER  = 3'd2,
    S_TRIP    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(RETRY_CLR_CYC - 1);
  localparam logic [7:0]       MAX_R     = 8'(MAX_RETRY);

  state_t           r_state, w_nxt;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_deb, r_clr, r_cool, w_deb, w_clr, w_cool;
  logic [7:0]       r_retry, w_retry, w_retry_inc;
  logic             r_dis, r_trip, r_locked;
  logic             w_trip, w_fault_s, w_active;

  assign w_fault_s   = r_sync[1];
  assign w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
  assign w_active    = (r_state == S_ARMED) || (r_state == S_FILTER) || (r_state == S_TRIP);

  always_comb begin
    w_nxt   = r_state;
    w_deb   = r_deb;
    w_clr   = '0;
    w_cool  = r_cool;
    w_retry = r_retry;
    w_trip  = 1'b0;
    // Dropping enable abandons any debounce or cooldown, but never escapes lockout.
    if (!enable && w_active) begin
      w_nxt   = S_OFF;
      w_deb   = '0;
      w_cool  = '0;
      w_retry = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_deb   = '0;
          w_cool  = '0;
          w_retry = '0;
          if (enable) w_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (w_fault_s) begin
            w_deb = CNT_W'(1);
            if (DEBOUNCE_CYC == 1) w_trip = 1'b1;
            else                   w_nxt  = S_FILTER;
          end else if (r_clr == CLR_LAST) begin
            w_retry = '0;
          end else begin
            w_clr = r_clr + CNT_W'(1);
          end
        end
        S_FILTER: begin
          if (!w_fault_s) begin
            w_nxt = S_ARMED;
            w_deb = '0;
          end else if (r_deb == DEB_LAST) begin
            w_trip = 1'b1;
          end else begin
            w_deb = r_deb + CNT_W'(1);
          end
        end
        S_TRIP: begin
          if (r_cool == COOL_LAST) begin
            if (r_retry >= MAX_R) w_nxt  = S_LOCKOUT;
            else if (w_fault_s)   w_cool = '0;
            else                  w_nxt  = S_ARMED;
          end else begin
            w_cool = r_cool + CNT_W'(1);
          end
        end
        S_LOCKOUT: begin
          if (clear && !w_fault_s) begin
            w_retry = '0;
            w_nxt   = enable ? S_ARMED : S_OFF;
          end
        end
        default: w_nxt = S_OFF;
      endcase
    end
    if (w_trip) begin
      w_nxt   = S_TRIP;
      w_retry = w_retry_inc;
      w_cool  = '0;
      w_deb   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_state  <= S_OFF;
      r_deb    <= '0;
      r_clr    <= '0;
      r_cool   <= '0;
      r_retry  <= '0;
      r_dis    <= 1'b1;
      r_trip   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], oc_fault_in};
      r_state  <= w_nxt;
      r_deb    <= w_deb;
      r_clr    <= w_clr;
      r_cool   <= w_cool;
      r_retry  <= w_retry;
      r_dis    <= (w_nxt == S_OFF) || (w_nxt == S_TRIP) || (w_nxt == S_LOCKOUT);
      r_trip   <= w_trip;
      r_locked <= (w_nxt == S_LOCKOUT);
    end
  end

  assign dis_out    = r_dis;
  assign trip_pulse = r_trip;
  assign locked     = r_locked;
  assign retry_cnt  = r_retry;
  assign state      = r_state;

endmodule

// File: tb/tb_current_off_ctrl.sv
// Directed bench for current_off_ctrl: expectations are queued with the cycle they are
// due on and popped/compared once the DUT has clocked that far.
module tb_current_off_ctrl;

  localparam logic [2:0] OFF = 3'd0, ARMED = 3'd1, FILTER = 3'd2, TRIP = 3'd3, LOCK = 3'd4;

  logic       clk = 1'b0;
  logic       reset, enable, oc_fault_in, clear;
  logic       dis_out, trip_pulse, locked;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  current_off_ctrl #(
    .DEBOUNCE_CYC(4), .COOLDOWN_CYC(16), .MAX_RETRY(3), .RETRY_CLR_CYC(64), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .oc_fault_in(oc_fault_in), .clear(clear),
    .dis_out(dis_out), .trip_pulse(trip_pulse), .locked(locked),
    .retry_cnt(retry_cnt), .state(state)
  );

  typedef struct {
    int         due;
    string      tag;
    logic [2:0] st;
    logic       dis, tp, lk;
    logic [7:0] rc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, n_tests = 0, n_fail = 0, tp_seen = 0;

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int dly, input string tag, input logic [2:0] st,
                           input logic dis, input logic tp, input logic lk, input logic [7:0] rc);
    exp_t e;
    e.due = cyc + dly; e.tag = tag; e.st = st; e.dis = dis; e.tp = tp; e.lk = lk; e.rc = rc;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cyc++;
      if (trip_pulse === 1'b1) tp_seen++;
      while (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        cmp({e.tag, ".state"}, {5'd0, state}, {5'd0, e.st});
        cmp({e.tag, ".dis"},   {7'd0, dis_out}, {7'd0, e.dis});
        cmp({e.tag, ".pulse"}, {7'd0, trip_pulse}, {7'd0, e.tp});
        cmp({e.tag, ".lock"},  {7'd0, locked}, {7'd0, e.lk});
        cmp({e.tag, ".retry"}, retry_cnt, e.rc);
      end
    end
  endtask

  // Three 8-cycle faults, 30 cycles apart; the third cooldown ends in lockout.
  task automatic three_trips(input string pfx);
    for (int k = 1; k <= 3; k++) begin
      oc_fault_in = 1'b1;
      run(8);
      oc_fault_in = 1'b0;
      if (k < 3) expect_at(14, $sformatf("%s_rearm%0d", pfx, k), ARMED, 0, 0, 0, 8'(k));
      else       expect_at(14, $sformatf("%s_lock", pfx), LOCK, 1, 0, 1, 8'd3);
      run(22);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; oc_fault_in = 1'b0; clear = 1'b0;
    run(2);
    expect_at(1, "rst", OFF, 1, 0, 0, 8'd0);
    run(1);

    // Release reset with enable high: one more edge in OFF, then ARMED.
    reset = 1'b0; enable = 1'b1;
    expect_at(1, "t1_armed", ARMED, 0, 0, 0, 8'd0);
    run(1);

    // Short fault (3 cycles) must not trip.
    tp_seen = 0;
    oc_fault_in = 1'b1;
    run(3);
    oc_fault_in = 1'b0;
    expect_at(2, "t2_filter", FILTER, 0, 0, 0, 8'd0);
    expect_at(3, "t2_back",   ARMED,  0, 0, 0, 8'd0);
    expect_at(8, "t2_quiet",  ARMED,  0, 0, 0, 8'd0);
    run(8);
    cmp("t2_no_pulse", 8'(tp_seen), 8'd0);

    // 8-cycle fault: trip on edge 6, 16 cycles of cooldown, back to ARMED.
    tp_seen = 0;
    oc_fault_in = 1'b1;
    expect_at(5, "t3_pre",       FILTER, 0, 0, 0, 8'd0);
    expect_at(6, "t3_trip",      TRIP,   1, 1, 0, 8'd1);
    expect_at(7, "t3_pulse_end", TRIP,   1, 0, 0, 8'd1);
    run(8);
    oc_fault_in = 1'b0;
    expect_at(13, "t3_cool_last", TRIP,  1, 0, 0, 8'd1);
    expect_at(14, "t3_rearm",     ARMED, 0, 0, 0, 8'd1);
    run(14);
    cmp("t3_one_pulse", 8'(tp_seen), 8'd1);

    // Fresh start, then drive into lockout.
    reset = 1'b1; run(1); reset = 1'b0; run(1);
    three_trips("t4");
    enable = 1'b0;
    expect_at(2, "t4_lock_en0", LOCK, 1, 0, 1, 8'd3);
    run(2);
    enable = 1'b1;
    oc_fault_in = 1'b1;
    run(3);
    clear = 1'b1; run(1); clear = 1'b0;
    expect_at(1, "t4_clr_ignored", LOCK, 1, 0, 1, 8'd3);
    run(1);
    oc_fault_in = 1'b0;
    run(3);
    clear = 1'b1;
    expect_at(1, "t4_clr_ok", ARMED, 0, 0, 0, 8'd0);
    run(1);
    clear = 1'b0;

    // One trip, then 64 fault-free ARMED cycles clear the retry count.
    oc_fault_in = 1'b1;
    run(8);
    oc_fault_in = 1'b0;
    expect_at(14, "t5_rearm",   ARMED, 0, 0, 0, 8'd1);
    expect_at(77, "t5_pre_clr", ARMED, 0, 0, 0, 8'd1);
    expect_at(78, "t5_clr",     ARMED, 0, 0, 0, 8'd0);
    run(78);

    // enable=0 mid-cooldown, then reset out of lockout.
    oc_fault_in = 1'b1;
    run(8);
    oc_fault_in = 1'b0;
    run(2);
    enable = 1'b0;
    expect_at(1, "t6_en0", OFF, 1, 0, 0, 8'd0);
    run(1);
    enable = 1'b1;
    expect_at(1, "t6_rearm", ARMED, 0, 0, 0, 8'd0);
    run(1);
    three_trips("t6");
    reset = 1'b1;
    expect_at(1, "t6_rst_lock", OFF, 1, 0, 0, 8'd0);
    run(1);
    reset = 1'b0;
    run(2);

    cmp("sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
